// File: rtl/gerador_tom_pkg.sv
// gerador_tom_pkg: shared types and constants for the tone generator.
// FSM state encoding, 3-bit note codes, octave-4 pitch table and the
// elaboration-time half-period helper.
package gerador_tom_pkg;

  typedef enum logic [1:0] {
    StOcioso      = 2'd0,
    StTocando     = 2'd1,
    StSustentando = 2'd2
  } estado_e;

  localparam logic [2:0] NOTA_SILENCIO = 3'd0;
  localparam logic [2:0] NOTA_DO       = 3'd1;
  localparam logic [2:0] NOTA_RE       = 3'd2;
  localparam logic [2:0] NOTA_MI       = 3'd3;
  localparam logic [2:0] NOTA_FA       = 3'd4;
  localparam logic [2:0] NOTA_SOL      = 3'd5;
  localparam logic [2:0] NOTA_LA       = 3'd6;
  localparam logic [2:0] NOTA_SI       = 3'd7;

  // Index 0 is silence; its entry is never used for a pitch.
  localparam int unsigned FREQ_HZ [8] = '{0, 262, 294, 330, 349, 392, 440, 494};

  // Half-period in clock cycles, floor(clock_hz / (2 * f)). Silence returns 1
  // so callers never see a zero reload value.
  function automatic int unsigned meio_periodo(input logic [2:0] nota,
                                               input int unsigned clock_hz);
    int unsigned h;
    if (nota == NOTA_SILENCIO) begin
      h = 1;
    end else begin
      h = clock_hz / (2 * FREQ_HZ[nota]);
    end
    return h;
  endfunction

endpackage

// File: rtl/divisor_tom.sv
// divisor_tom: half-period counter producing a 50% duty square wave.
// Counts 0..meio_i-1 while enabled; on the last count it wraps and toggles
// the output. clear_i zeroes both the count and the output.
module divisor_tom #(
  parameter int unsigned Largura = 11
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic [Largura-1:0] meio_i,
  output logic               tom_o
);

  logic [Largura-1:0] cont_q, cont_d;
  logic               tom_q, tom_d;

  // Next count and output level; clear has priority over counting.
  always_comb begin
    cont_d = cont_q;
    tom_d  = tom_q;
    if (clear_i) begin
      cont_d = '0;
      tom_d  = 1'b0;
    end else if (en_i) begin
      // >= keeps the counter bounded if the reload value ever shrinks.
      if (cont_q >= meio_i - Largura'(1)) begin
        cont_d = '0;
        tom_d  = ~tom_q;
      end else begin
        cont_d = cont_q + Largura'(1);
      end
    end
  end

  // Counter and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cont_q <= '0;
      tom_q  <= 1'b0;
    end else begin
      cont_q <= cont_d;
      tom_q  <= tom_d;
    end
  end

  assign tom_o = tom_q;

endmodule

// File: rtl/gerador_tom.sv
// gerador_tom: turns the enable + 3-bit note link into a buzzer square wave.
// Input register -> stability filter -> note FSM -> divisor_tom.
// Optional release phase after silence is built when GERADOR_TOM_SUSTAIN_EN
// is defined; otherwise accepted silence stops the tone immediately.
module gerador_tom
  import gerador_tom_pkg::*;
#(
  parameter int unsigned CLOCK_HZ       = 50_000_000,
  parameter int unsigned ESTAVEL_CICLOS = 4,
  parameter int unsigned SUSTAIN_CICLOS = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] nota,
  output logic       buzzer,
  output logic       tocando,
  output logic [2:0] nota_atual,
  output logic [1:0] db_estado
);

  // Lowest pitch has the longest half-period and sets the divider width.
  localparam int unsigned HMax = meio_periodo(NOTA_DO, CLOCK_HZ);
  localparam int unsigned DivW = (HMax > 1) ? $clog2(HMax) : 1;
  localparam int unsigned CntW = $clog2(ESTAVEL_CICLOS + 1);

  if (ESTAVEL_CICLOS == 0 || SUSTAIN_CICLOS == 0) begin : g_param_invalido
    $error("gerador_tom: ESTAVEL_CICLOS and SUSTAIN_CICLOS must be >= 1");
  end

  logic [2:0]      c_q, c_d;
  logic [2:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            aceito_q, aceito_d;
  estado_e         estado_q, estado_d;
  logic [2:0]      nota_q, nota_d;
  logic            carregar;
  logic            div_clear;
  logic [DivW-1:0] meio;

`ifdef GERADOR_TOM_SUSTAIN_EN
  localparam int unsigned RelW = (SUSTAIN_CICLOS > 1) ? $clog2(SUSTAIN_CICLOS) : 1;
  logic [RelW-1:0] rel_q, rel_d;
`endif

  // Input sampling and stability filter. aceito_q pulses for one cycle on the
  // edge after the candidate has been seen ESTAVEL_CICLOS times in a row.
  always_comb begin
    c_d      = enable ? nota : NOTA_SILENCIO;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    aceito_d = 1'b0;
    if (c_q != cand_q) begin
      cand_d   = c_q;
      cnt_d    = CntW'(1);
      aceito_d = (ESTAVEL_CICLOS == 1);
    end else if (cnt_q != CntW'(ESTAVEL_CICLOS)) begin
      cnt_d    = cnt_q + CntW'(1);
      aceito_d = (cnt_q == CntW'(ESTAVEL_CICLOS - 1));
    end
  end

  // Filter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c_q      <= NOTA_SILENCIO;
      cand_q   <= NOTA_SILENCIO;
      cnt_q    <= '0;
      aceito_q <= 1'b0;
    end else begin
      c_q      <= c_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      aceito_q <= aceito_d;
    end
  end

  // Note FSM: cand_q still holds the accepted code in the cycle aceito_q is high.
  always_comb begin
    estado_d = estado_q;
    nota_d   = nota_q;
    carregar = 1'b0;
`ifdef GERADOR_TOM_SUSTAIN_EN
    rel_d    = '0;
`endif
    unique case (estado_q)
      StOcioso: begin
        if (aceito_q && cand_q != NOTA_SILENCIO) begin
          estado_d = StTocando;
          nota_d   = cand_q;
          carregar = 1'b1;
        end
      end
      StTocando: begin
        if (aceito_q) begin
          if (cand_q == NOTA_SILENCIO) begin
`ifdef GERADOR_TOM_SUSTAIN_EN
            estado_d = StSustentando;
`else
            estado_d = StOcioso;
`endif
          end else if (cand_q != nota_q) begin
            nota_d   = cand_q;
            carregar = 1'b1;
          end
        end
      end
`ifdef GERADOR_TOM_SUSTAIN_EN
      StSustentando: begin
        // A new note wins over a release ending on the same edge.
        if (aceito_q && cand_q != NOTA_SILENCIO) begin
          estado_d = StTocando;
          nota_d   = cand_q;
          carregar = 1'b1;
        end else if (rel_q == RelW'(SUSTAIN_CICLOS - 1)) begin
          estado_d = StOcioso;
        end else begin
          rel_d = rel_q + RelW'(1);
        end
      end
`endif
      default: estado_d = StOcioso;
    endcase
    if (estado_d == StOcioso) begin
      nota_d = NOTA_SILENCIO;
    end
  end

  // FSM state, current note and release counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= StOcioso;
      nota_q   <= NOTA_SILENCIO;
`ifdef GERADOR_TOM_SUSTAIN_EN
      rel_q    <= '0;
`endif
    end else begin
      estado_q <= estado_d;
      nota_q   <= nota_d;
`ifdef GERADOR_TOM_SUSTAIN_EN
      rel_q    <= rel_d;
`endif
    end
  end

  // Half-period reload for the sounding note, folded to constants at elaboration.
  always_comb begin
    case (nota_q)
      NOTA_DO:  meio = DivW'(meio_periodo(NOTA_DO, CLOCK_HZ));
      NOTA_RE:  meio = DivW'(meio_periodo(NOTA_RE, CLOCK_HZ));
      NOTA_MI:  meio = DivW'(meio_periodo(NOTA_MI, CLOCK_HZ));
      NOTA_FA:  meio = DivW'(meio_periodo(NOTA_FA, CLOCK_HZ));
      NOTA_SOL: meio = DivW'(meio_periodo(NOTA_SOL, CLOCK_HZ));
      NOTA_LA:  meio = DivW'(meio_periodo(NOTA_LA, CLOCK_HZ));
      NOTA_SI:  meio = DivW'(meio_periodo(NOTA_SI, CLOCK_HZ));
      default:  meio = DivW'(1);
    endcase
  end

  // Divider restarts on every note load and is parked at zero when idle.
  assign div_clear = carregar || (estado_d == StOcioso);

  divisor_tom #(
    .Largura (DivW)
  ) u_divisor_tom (
    .clk_i   (clock),
    .rst_i   (reset),
    .clear_i (div_clear),
    .en_i    (estado_q != StOcioso),
    .meio_i  (meio),
    .tom_o   (buzzer)
  );

  assign tocando    = (estado_q != StOcioso);
  assign nota_atual = nota_q;
  assign db_estado  = estado_q;

endmodule

// File: tb/tb_gerador_tom.sv
// tb_gerador_tom: self-checking bench for gerador_tom.
// A cycle-level reference model (run-length filter, elapsed-time tone phase)
// is compared against the DUT on every falling edge; table vectors and
// hand-written sequences cover latency, periods, glitches, release and reset.
module tb_gerador_tom;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned EST    = 4;
  localparam int unsigned SUS    = 100;
`ifdef GERADOR_TOM_SUSTAIN_EN
  localparam bit TemSustain = 1'b1;
`else
  localparam bit TemSustain = 1'b0;
`endif

  localparam int unsigned FREQ [8] = '{1, 262, 294, 330, 349, 392, 440, 494};

  function automatic int unsigned h_of(input int unsigned n);
    return CLK_HZ / (2 * FREQ[n]);
  endfunction

  logic       clock  = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] nota   = 3'd0;
  logic       buzzer;
  logic       tocando;
  logic [2:0] nota_atual;
  logic [1:0] db_estado;

  int n_cmp = 0;
  int n_err = 0;

  gerador_tom #(
    .CLOCK_HZ       (CLK_HZ),
    .ESTAVEL_CICLOS (EST),
    .SUSTAIN_CICLOS (SUS)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .nota       (nota),
    .buzzer     (buzzer),
    .tocando    (tocando),
    .nota_atual (nota_atual),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
               nome, got, got, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_st: 0 idle, 1 playing, 2 releasing. m_t counts edges since the last note
  // load; the buzzer level is simply floor(m_t / H) mod 2.
  int         m_st = 0;
  logic [2:0] m_note = 3'd0;
  int         m_t = 0;
  int         m_rel = 0;
  int         prev_s = 0;
  int         run = 1;
  bit         acc1 = 0, acc2 = 0;
  int         acc1_code = 0, acc2_code = 0;
  int         s_now;
  bit         a_now;
  int         ac_now;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_st = 0; m_note = 3'd0; m_t = 0; m_rel = 0;
      prev_s = 0; run = 1; acc1 = 0; acc2 = 0; acc1_code = 0; acc2_code = 0;
    end else begin
      // Act on the code accepted one edge earlier.
      a_now  = acc2;
      ac_now = acc2_code;
      if (m_st == 0) begin
        if (a_now && ac_now != 0) begin m_st = 1; m_note = 3'(ac_now); m_t = 0; end
      end else if (m_st == 1) begin
        if (a_now && ac_now == 0) begin
          if (TemSustain) begin m_st = 2; m_rel = 0; m_t++; end
          else m_st = 0;
        end else if (a_now && ac_now != int'(m_note)) begin
          m_note = 3'(ac_now); m_t = 0;
        end else begin
          m_t++;
        end
      end else begin
        if (a_now && ac_now != 0) begin m_st = 1; m_note = 3'(ac_now); m_t = 0; end
        else if (m_rel == SUS - 1) m_st = 0;
        else begin m_rel++; m_t++; end
      end
      // A run of EST identical samples ending at edge n is accepted at n+1.
      acc2 = acc1; acc2_code = acc1_code;
      s_now = enable ? int'(nota) : 0;
      if (s_now == prev_s) begin
        if (run <= int'(EST)) run++;
      end else begin
        run = 1; prev_s = s_now;
      end
      acc1 = (run == int'(EST));
      acc1_code = s_now;
    end
  end

  function automatic logic [6:0] modelo_saidas();
    logic b;
    b = (m_st != 0) && (((m_t / int'(h_of(m_note))) % 2) == 1);
    return {b, (m_st != 0), (m_st == 0) ? 3'd0 : m_note, 2'(m_st)};
  endfunction

  // Continuous comparison: {buzzer, tocando, nota_atual, db_estado}.
  always @(negedge clock) begin
    check("modelo buz/toc/nota/db", {25'd0, buzzer, tocando, nota_atual, db_estado},
          {25'd0, modelo_saidas()});
  end

  // ---------------- helpers ----------------
  task automatic aplica(input logic en, input logic [2:0] n);
    @(negedge clock);
    enable = en;
    nota   = n;
  endtask

  // Call right after aplica: waits the capture edge, then counts edges until
  // nota_atual shows the target.
  task automatic latencia(input logic [2:0] alvo, output int edges);
    bit ok;
    ok = 0;
    edges = 0;
    @(posedge clock);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clock); #1;
      edges++;
      if (nota_atual == alvo) ok = 1;
    end
  endtask

  // Edges from now until the next buzzer rising transition.
  task automatic espera_subida(output int n);
    bit ok;
    logic prev;
    ok = 0;
    n = 0;
    prev = buzzer;
    for (int i = 0; i < 6000 && !ok; i++) begin
      @(posedge clock); #1;
      n++;
      if (buzzer && !prev) ok = 1;
      prev = buzzer;
    end
  endtask

  typedef struct {
    bit         en;
    logic [2:0] n;
    int         hold;
    logic [2:0] exp_nota;
    bit         exp_toc;
    logic [1:0] exp_db;
  } vec_t;

  vec_t tab [6];

  initial begin
    int edges;
    int per;
    int exp_drop;
    bit dropped;
    bit ok;

    tab[0] = '{1'b1, 3'd2, 8, 3'd2, 1'b1, 2'd1};
    tab[1] = '{1'b1, 3'd4, 8, 3'd4, 1'b1, 2'd1};
    tab[2] = '{1'b1, 3'd4, 3, 3'd4, 1'b1, 2'd1};
    tab[3] = '{1'b0, 3'd4, 8, TemSustain ? 3'd4 : 3'd0, TemSustain, TemSustain ? 2'd2 : 2'd0};
    tab[4] = '{1'b1, 3'd7, 8, 3'd7, 1'b1, 2'd1};
    tab[5] = '{1'b1, 3'd0, 8, TemSustain ? 3'd7 : 3'd0, TemSustain, TemSustain ? 2'd2 : 2'd0};

    // Reset values.
    #12;
    check("reset buzzer", {31'd0, buzzer}, 32'd0);
    check("reset tocando", {31'd0, tocando}, 32'd0);
    check("reset nota_atual", {29'd0, nota_atual}, 32'd0);
    check("reset db_estado", {30'd0, db_estado}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Table vectors.
    for (int i = 0; i < 6; i++) begin
      aplica(tab[i].en, tab[i].n);
      repeat (tab[i].hold) @(negedge clock);
      check($sformatf("tab[%0d] nota_atual", i), {29'd0, nota_atual}, {29'd0, tab[i].exp_nota});
      check($sformatf("tab[%0d] tocando", i), {31'd0, tocando}, {31'd0, tab[i].exp_toc});
      check($sformatf("tab[%0d] db_estado", i), {30'd0, db_estado}, {30'd0, tab[i].exp_db});
    end
    aplica(1'b0, 3'd0);
    repeat (SUS + 20) @(negedge clock);

    // Latency and period of La (H=1136).
    aplica(1'b1, 3'd6);
    latencia(3'd6, edges);
    check("latencia nota 6", edges, EST + 1);
    check("tocando nota 6", {31'd0, tocando}, 32'd1);
    espera_subida(per);
    check("primeira subida nota 6", per, h_of(6));
    espera_subida(per);
    check("periodo nota 6", per, 2 * h_of(6));

    // Glitch 1 -> 3 for 3 samples -> 1 must be ignored.
    aplica(1'b1, 3'd1);
    latencia(3'd1, edges);
    check("latencia nota 1", edges, EST + 1);
    repeat (200) @(negedge clock);
    nota = 3'd3;
    repeat (3) @(negedge clock);
    nota = 3'd1;
    repeat (30) @(negedge clock);
    check("glitch nota_atual", {29'd0, nota_atual}, 32'd1);
    check("glitch db_estado", {30'd0, db_estado}, 32'd1);

    // Switch 1 -> 5 (H=1275).
    aplica(1'b1, 3'd5);
    latencia(3'd5, edges);
    check("latencia troca 5", edges, EST + 1);
    check("buzzer zerado na troca", {31'd0, buzzer}, 32'd0);
    espera_subida(per);
    check("primeira subida nota 5", per, h_of(5));
    espera_subida(per);
    check("periodo nota 5", per, 2 * h_of(5));

    // Silence while playing 3.
    aplica(1'b1, 3'd3);
    latencia(3'd3, edges);
    check("latencia nota 3", edges, EST + 1);
    aplica(1'b0, 3'd3);
    @(posedge clock);
    exp_drop = TemSustain ? int'(EST + 1 + SUS) : int'(EST + 1);
    edges = 0;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clock); #1;
      edges++;
      if (!tocando) ok = 1;
    end
    check("queda de tocando", edges, exp_drop);
    check("buzzer apos silencio", {31'd0, buzzer}, 32'd0);
    check("nota_atual apos silencio", {29'd0, nota_atual}, 32'd0);

`ifdef GERADOR_TOM_SUSTAIN_EN
    // New note accepted mid-release returns to playing without a drop.
    aplica(1'b1, 3'd3);
    latencia(3'd3, edges);
    aplica(1'b0, 3'd3);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clock); #1;
      if (db_estado == 2'd2) ok = 1;
    end
    check("entrou em sustentando", {31'd0, ok}, 32'd1);
    repeat (45) @(posedge clock);
    aplica(1'b1, 3'd7);
    dropped = 0;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(posedge clock); #1;
      if (!tocando) dropped = 1;
      if (nota_atual == 3'd7) ok = 1;
    end
    check("sem queda no aborto", {31'd0, dropped}, 32'd0);
    check("aborto nota_atual", {29'd0, nota_atual}, 32'd7);
    check("aborto db_estado", {30'd0, db_estado}, 32'd1);
    espera_subida(per);
    check("primeira subida nota 7", per, h_of(7));
`endif

    // Asynchronous reset mid-tone, between edges.
    aplica(1'b1, 3'd2);
    latencia(3'd2, edges);
    espera_subida(per);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("reset assinc buzzer", {31'd0, buzzer}, 32'd0);
    check("reset assinc tocando", {31'd0, tocando}, 32'd0);
    check("reset assinc nota_atual", {29'd0, nota_atual}, 32'd0);
    #1 reset = 1'b0;
    latencia(3'd2, edges);
    check("latencia apos reset", edges, EST + 1);

    // Randomized segments, checked by the model on every cycle.
    for (int i = 0; i < 40; i++) begin
      int hold;
      aplica($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)));
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 1500);
      repeat (hold) @(negedge clock);
    end

    repeat (10) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gerador_tom.md
# gerador_tom

Receiving end of the 3-bit note link that the datapath drives toward the sound board. Takes the `enable` + `nota[2:0]` code and produces a square-wave `buzzer` output at the matching musical pitch. A stability filter rejects glitches, and a state machine handles note start, note change and silence. It sits beside the datapath and replaces the external board for on-FPGA audio.

## Interface
- `CLOCK_HZ`, default 50_000_000: system clock frequency; sets the divider half-periods.
- `ESTAVEL_CICLOS`, default 4: consecutive identical samples required to accept a code (≥1).
- `SUSTAIN_CICLOS`, default 1000: release length after silence; used only with `GERADOR_TOM_SUSTAIN_EN`.
- `clock` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `enable` input 1: link active; when 0, the code is treated as silence.
- `nota` input 3: 0 = silence; 1..7 = Dó, Ré, Mi, Fá, Sol, Lá, Si (octave 4).
- `buzzer` output 1: square wave, 50% duty.
- `tocando` output 1: high while in TOCANDO or SUSTENTANDO.
- `nota_atual` output 3: note currently sounding; 0 when idle.
- `db_estado` output 2: FSM state encoding, for debug.

## Operation
- Effective code `c = enable ? nota : 0`, registered once per clock.
- Stability filter:
  - Candidate register plus counter.
  - When `c` differs from the candidate, the candidate loads `c` and the counter loads 1.
  - Otherwise the counter increments, saturating at `ESTAVEL_CICLOS`.
  - The candidate is accepted on the edge where the counter reaches `ESTAVEL_CICLOS`.
- Pitches: 262, 294, 330, 349, 392, 440, 494 Hz.
- Half-period `H[n] = CLOCK_HZ / (2·f[n])`, integer floor, computed at elaboration. Divider width is `$clog2(max H)`.
- FSM states:
  - OCIOSO=0: accepted nonzero code → TOCANDO. Load `nota_atual`, clear divider, `buzzer`=0.
  - TOCANDO=1: divider counts 0..H−1; on H−1 it wraps to 0 and toggles `buzzer`.
    - Accepted different nonzero code → stay in TOCANDO; reload note, clear divider, `buzzer`=0.
    - Accepted same code → no effect.
    - Accepted 0 → SUSTENTANDO if the macro is defined, else OCIOSO.
  - SUSTENTANDO=2: tone continues with unchanged `nota_atual`; release counter counts 0..SUSTAIN_CICLOS−1.
    - At the end → OCIOSO.
    - Accepted nonzero code → TOCANDO with that note; release aborted, divider cleared.
- In OCIOSO: `buzzer`=0, `nota_atual`=0, divider and release counter held at 0.
- Codes that are not yet accepted never affect the tone. The old note keeps playing until a replacement is accepted.
- Reset mid-note: all outputs drop to their reset values immediately (asynchronous), state = OCIOSO.

## Timing
- Reset values: `buzzer`=0, `tocando`=0, `nota_atual`=0, `db_estado`=0, filter candidate=0, counters=0.
- Input registration adds 1 cycle.
- A code presented at edge k is accepted at edge k+`ESTAVEL_CICLOS`.
- `nota_atual`/`tocando` update one cycle after acceptance, so total latency is `ESTAVEL_CICLOS`+1 edges.
- First `buzzer` rise occurs H cycles after `nota_atual` updates. Period = 2·H cycles exactly.
- A glitch shorter than `ESTAVEL_CICLOS` samples is ignored completely.
- Release: `tocando` falls exactly `SUSTAIN_CICLOS` cycles after entering SUSTENTANDO; `buzzer` is forced to 0 in the same cycle.
- Acceptance and release end on the same edge: acceptance wins (→ TOCANDO).

## Configuration
- `GERADOR_TOM_SUSTAIN_EN` defined:
  - SUSTENTANDO state and release counter are present.
  - `SUSTAIN_CICLOS` is honoured.
- Not defined:
  - Accepted silence goes TOCANDO → OCIOSO directly; the tone stops on that edge.
  - No release counter logic is generated.
  - `db_estado` never reads 2.

## Structure
- `gerador_tom_pkg` holds:
  - state enum;
  - note code constants `NOTA_SILENCIO`..`NOTA_SI`;
  - frequency table;
  - function `meio_periodo(nota, clock_hz)`.
- Sub-module `divisor_tom`:
  - ports: clear, half-period load value, enable;
  - output: toggle with wrap.
- Filter and FSM stay in `gerador_tom`.

## Test plan
All scenarios run with `CLOCK_HZ`=1_000_000, `ESTAVEL_CICLOS`=4, `SUSTAIN_CICLOS`=100.
- `enable`=1, `nota`=6 held → `nota_atual`=6 after 5 edges; `buzzer` period 2272 cycles (H=1136); `tocando`=1.
- `nota`=1 → 3 pulse for 3 cycles then back to 1 → `nota_atual` stays 1; `buzzer` phase undisturbed.
- Playing 1 (H=1908), switch to 5 held → after 5 edges `nota_atual`=5, `buzzer`=0, new period 2550 (H=1275).
- Playing 3, `enable`→0:
  - with macro: `tocando` holds 100 cycles after acceptance, then drops, `buzzer`=0;
  - without macro: drops 5 edges after `enable` falls.
- SUSTENTANDO at release cycle 50, `nota`=7 applied → returns to TOCANDO, `nota_atual`=7, H=1012; no drop of `tocando`.
- `reset` asserted mid-tone, between clock edges → `buzzer`, `tocando`, `nota_atual` all 0 before the next edge; after release, a stable code needs the full 5-edge latency again.
